// File: rtl/data_memory_banked.sv
// Banked data memory with a valid/ready request port, byte enables and a
// post-reset zero-fill sweep; responses come back in order after RD_LAT cycles.
module data_memory_banked #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [DATA_W/8-1:0] req_be_i,
   input  logic [DATA_W-1:0]   req_wdata_i,
   output logic                rsp_valid_o,
   output logic [DATA_W-1:0]   rsp_rdata_o,
   output logic                rsp_err_o,
   output logic                init_done_o
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t            state_q;
   logic [IDX_W-1:0]  ptr_q;
   logic              ready_q;
   logic              done_q;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [RD_LAT-1:0] vld_q;
   logic [RD_LAT-1:0] err_q;
   logic [DATA_W-1:0] dat_q [RD_LAT];

   logic [ADDR_W-1:0] word_addr;
   logic [IDX_W-1:0]  idx;
   logic              accept;
   logic              misalign;
   logic              oob;
   logic              req_err;
   logic [DATA_W-1:0] rd_d;

   assign word_addr = req_addr_i >> OFF_W;
   assign idx       = word_addr[IDX_W-1:0];
   assign misalign  = |(req_addr_i & ADDR_W'(BYTES - 1));
   assign oob       = word_addr >= ADDR_W'(DEPTH);
   assign req_err   = misalign | oob;
   assign accept    = req_valid_i & ready_q;
   // Errored requests and writes never touch the array and answer with zero data.
   assign rd_d      = (accept && !req_we_i && !req_err) ? mem_q[idx] : '0;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               ptr_q <= ptr_q + IDX_W'(1);
               if (ptr_q == IDX_W'(DEPTH - 1)) begin
                  state_q <= ST_RUN;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
            ST_RUN: begin
            end
            default: state_q <= ST_INIT;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_n_i) begin
         if (state_q == ST_INIT) begin
            mem_q[ptr_q] <= '0;
         end else if (accept && req_we_i && !req_err) begin
            for (int b = 0; b < BYTES; b++) begin
               if (req_be_i[b]) mem_q[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Response shift pipeline; reset flushes every in-flight response.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         vld_q <= '0;
         err_q <= '0;
         for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
      end else begin
         vld_q[0] <= accept;
         err_q[0] <= accept & req_err;
         dat_q[0] <= rd_d;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            err_q[i] <= err_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign req_ready_o = ready_q;
   assign init_done_o = done_q;
   assign rsp_valid_o = vld_q[RD_LAT-1];
   assign rsp_err_o   = err_q[RD_LAT-1];
   assign rsp_rdata_o = dat_q[RD_LAT-1];

endmodule

// File: tb/tb_data_memory_banked.sv
// Drives one request stream into two instances (RD_LAT 1 and 3) and compares
// every cycle against a word-array model with per-instance response queues.
module tb_data_memory_banked;

   localparam int DEPTH = 32;

   typedef struct {
      int          due;
      logic [31:0] d;
      logic        e;
   } rsp_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;

   logic        rdy1, v1, e1, done1;
   logic [31:0] d1;
   logic        rdy3, v3, e3, done3;
   logic [31:0] d3;

   data_memory_banked #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(1)) u_dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy1),
      .req_we_i(req_we), .req_addr_i(req_addr), .req_be_i(req_be), .req_wdata_i(req_wdata),
      .rsp_valid_o(v1), .rsp_rdata_o(d1), .rsp_err_o(e1), .init_done_o(done1)
   );

   data_memory_banked #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(3)) u_dut3 (
      .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy3),
      .req_we_i(req_we), .req_addr_i(req_addr), .req_be_i(req_be), .req_wdata_i(req_wdata),
      .rsp_valid_o(v3), .rsp_rdata_o(d3), .rsp_err_o(e3), .init_done_o(done3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          init_cnt = 0;
   int          rel = 0;
   bit          run = 0;
   bit          seen = 0;
   logic [31:0] mm [DEPTH];
   rsp_t        q1[$];
   rsp_t        q3[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      rsp_t r;
      bit   ev;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         run = 0; init_cnt = 0; rel = 0; seen = 0;
         q1.delete(); q3.delete();
         foreach (mm[i]) mm[i] = '0;
      end else begin
         rel++;
         if (!run) begin
            init_cnt++;
            if (init_cnt == DEPTH) run = 1;
         end
      end
      @(negedge clk);
      check("ready1", rdy1, run);
      check("done1", done1, run);
      check("ready3", rdy3, run);
      check("done3", done3, run);
      if (done1 && !seen) begin
         seen = 1;
         check("init_cycles", rel, DEPTH);
      end
      ev = (q1.size() > 0) && (q1[0].due == cyc);
      r  = '{0, 32'h0, 1'b0};
      if (ev) r = q1.pop_front();
      check("rsp_valid1", v1, ev);
      check("rsp_rdata1", d1, r.d);
      check("rsp_err1", e1, r.e);
      ev = (q3.size() > 0) && (q3[0].due == cyc);
      r  = '{0, 32'h0, 1'b0};
      if (ev) r = q3.pop_front();
      check("rsp_valid3", v3, ev);
      check("rsp_rdata3", d3, r.d);
      check("rsp_err3", e3, r.e);
   endtask

   task automatic model_accept(input bit we, input logic [31:0] a, input logic [3:0] be,
                               input logic [31:0] wd);
      logic [31:0] w;
      logic [31:0] rd;
      bit          err;
      w   = a / 4;
      err = (a % 4 != 0) || (w >= DEPTH);
      rd  = '0;
      if (!err) begin
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) mm[w][8*b +: 8] = wd[8*b +: 8];
         end else begin
            rd = mm[w];
         end
      end
      q1.push_back('{cyc + 1, rd, err});
      q3.push_back('{cyc + 3, rd, err});
   endtask

   task automatic req(input bit we, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_be    = be;
      req_wdata = wd;
      if (run) model_accept(we, a, be, wd);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_be    = '0;
      req_wdata = '0;
      foreach (mm[i]) mm[i] = '0;
      @(negedge clk);
      idle(3);
      rst_n = 1'b1;

      // Requests offered during the sweep must be ignored.
      req(1'b1, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF);
      req(1'b0, 32'h0000_0004, 4'h0, 32'h0);
      idle(DEPTH + 2);

      req(1'b0, 32'h0000_0000, 4'h0, 32'h0);
      req(1'b0, 32'h0000_007C, 4'h0, 32'h0);
      req(1'b1, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF);
      req(1'b0, 32'h0000_0000, 4'h0, 32'h0);
      req(1'b1, 32'h0000_0004, 4'hF, 32'h1122_3344);
      req(1'b1, 32'h0000_0004, 4'h5, 32'hAABB_CCDD);
      req(1'b0, 32'h0000_0004, 4'h0, 32'h0);
      req(1'b1, 32'h0000_0008, 4'h0, 32'h5555_5555);
      req(1'b0, 32'h0000_0002, 4'h0, 32'h0);
      req(1'b0, 32'h0000_0080, 4'h0, 32'h0);
      req(1'b1, 32'h0000_0081, 4'hF, 32'h1234_5678);
      idle(2);
      req(1'b0, 32'h0000_0000, 4'h0, 32'h0);
      req(1'b0, 32'h0000_0004, 4'h0, 32'h0);
      req(1'b0, 32'h0000_0008, 4'h0, 32'h0);
      req(1'b0, 32'h0000_000C, 4'h0, 32'h0);
      idle(5);

      for (int k = 0; k < 400; k++) begin
         int unsigned sel;
         logic [31:0] a;
         if ($urandom_range(0, 9) < 2) begin
            idle(1);
         end else begin
            sel = $urandom_range(0, 9);
            if (sel < 7)      a = $urandom_range(0, DEPTH - 1) * 4;
            else if (sel < 9) a = $urandom_range(0, 255);
            else              a = $urandom;
            req(bit'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
         end
      end
      idle(5);

      // Reset with reads still in flight in the RD_LAT=3 instance.
      req(1'b1, 32'h0000_0004, 4'hF, 32'hCAFE_F00D);
      req(1'b0, 32'h0000_0000, 4'h0, 32'h0);
      req(1'b0, 32'h0000_0004, 4'h0, 32'h0);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(DEPTH + 2);
      req(1'b0, 32'h0000_0004, 4'h0, 32'h0);
      req(1'b0, 32'h0000_0000, 4'h0, 32'h0);
      idle(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
